// File: rtl/acorn_pkg.sv
// ACORN-128 shared types and constants.
// Used by the init, AD, encrypt and finalization stages.
package acorn_pkg;

   localparam int ACORN_STATE_W      = 293;
   localparam int ACORN_PAD_STEPS    = 256;
   localparam int ACORN_CA_ONE_STEPS = 128;

   typedef logic [ACORN_STATE_W-1:0] acorn_state_t;

   typedef enum logic [1:0] {
      IDLE,
      MSG,
      PAD,
      DONE
   } enc_fsm_t;

   function automatic logic maj(
      input logic x,
      input logic y,
      input logic z
   );
      return (x & y) ^ (x & z) ^ (y & z);
   endfunction

   function automatic logic ch(
      input logic x,
      input logic y,
      input logic z
   );
      return (x & y) ^ (~x & z);
   endfunction

endpackage

// File: rtl/acorn_step.sv
// One ACORN-128 state update, purely combinational.
// Shared by the init, encrypt and finalization stages.
module acorn_step
   import acorn_pkg::*;
(
   input  acorn_state_t state,
   input  logic         m,
   input  logic         ca,
   input  logic         cb,
   output acorn_state_t next_state,
   output logic         ks
);

   acorn_state_t s;
   logic         fb;

   // LFSR feedback is chained: each line sees prior updates
   always_comb begin
      s      = state;
      s[289] = s[289] ^ s[235] ^ s[230];
      s[230] = s[230] ^ s[196] ^ s[193];
      s[193] = s[193] ^ s[160] ^ s[154];
      s[154] = s[154] ^ s[111] ^ s[107];
      s[107] = s[107] ^ s[66]  ^ s[61];
      s[61]  = s[61]  ^ s[23]  ^ s[0];

      ks = s[12] ^ s[154]
         ^ maj(s[235], s[61], s[193])
         ^ ch(s[230], s[111], s[66]);

      fb = s[0] ^ ~s[107]
         ^ maj(s[244], s[23], s[160])
         ^ (ca & s[196])
         ^ (cb & ks)
         ^ m;

      next_state = {fb, s[ACORN_STATE_W-1:1]};
   end

endmodule

// File: rtl/acorn_encrypt_process.sv
// ACORN-128 encryption stage: bit-serial plaintext
// absorption followed by the fixed padding phase.
module acorn_encrypt_process
   import acorn_pkg::*;
#(
   parameter int LEN_W        = 16,
   parameter int PAD_STEPS    = ACORN_PAD_STEPS,
   parameter int CA_ONE_STEPS = ACORN_CA_ONE_STEPS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  acorn_state_t     state_in,
   input  logic [LEN_W-1:0] pc_len,
   input  logic             pt_bit,
   input  logic             pt_valid,
   output logic             pt_ready,
   output logic             ct_bit,
   output logic             ct_valid,
   output logic             busy,
   output logic             done,
   output acorn_state_t     state_out
);

   localparam logic [7:0] PAD_LAST = 8'(PAD_STEPS - 1);

   enc_fsm_t         fsm;
   enc_fsm_t         fsm_nx;
   acorn_state_t     st;
   acorn_state_t     st_step;
   logic [LEN_W-1:0] len;
   logic [LEN_W-1:0] cnt;
   logic [7:0]       pcnt;
   logic             step_m;
   logic             step_ca;
   logic             ks;
   logic             accept;
   logic             ct_bit_q;
   logic             ct_valid_q;

   acorn_step u_step (
      .state      (st),
      .m          (step_m),
      .ca         (step_ca),
      .cb         (1'b0),
      .next_state (st_step),
      .ks         (ks)
   );

   always_comb begin
      fsm_nx   = fsm;
      step_m   = 1'b0;
      step_ca  = 1'b0;
      accept   = 1'b0;
      pt_ready = 1'b0;
      unique case (fsm)
         IDLE: begin
            if (start)
               fsm_nx = (pc_len != '0) ? MSG : PAD;
         end
         MSG: begin
            pt_ready = (cnt < len);
            accept   = pt_valid & pt_ready;
            step_m   = pt_bit;
            step_ca  = 1'b1;
            if (accept && cnt == len - LEN_W'(1))
               fsm_nx = PAD;
         end
         PAD: begin
            step_m  = (pcnt == 8'd0);
            step_ca = (int'(pcnt) < CA_ONE_STEPS);
            if (pcnt == PAD_LAST)
               fsm_nx = DONE;
         end
         DONE: fsm_nx = IDLE;
         default: fsm_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) fsm <= IDLE;
      else      fsm <= fsm_nx;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st         <= '0;
         len        <= '0;
         cnt        <= '0;
         pcnt       <= '0;
         ct_bit_q   <= 1'b0;
         ct_valid_q <= 1'b0;
      end else begin
         ct_valid_q <= accept;
         unique case (fsm)
            IDLE: begin
               if (start) begin
                  st   <= state_in;
                  len  <= pc_len;
                  cnt  <= '0;
                  pcnt <= '0;
               end
            end
            MSG: begin
               if (accept) begin
                  st       <= st_step;
                  ct_bit_q <= pt_bit ^ ks;
                  cnt      <= cnt + LEN_W'(1);
               end
            end
            PAD: begin
               st <= st_step;
               // pcnt parks at the last step
               if (pcnt != PAD_LAST)
                  pcnt <= pcnt + 8'd1;
            end
            default: ;
         endcase
      end
   end

   assign ct_bit    = ct_bit_q;
   assign ct_valid  = ct_valid_q;
   assign busy      = (fsm == MSG) || (fsm == PAD);
   assign done      = (fsm == DONE);
   assign state_out = st;

endmodule

// File: tb/tb_acorn_encrypt_process.sv
// Directed bench for acorn_encrypt_process with a
// ciphertext scoreboard and an independent step model.
module tb_acorn_encrypt_process;
   import acorn_pkg::*;

   localparam int LEN_W = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             start = 1'b0;
   logic [292:0]     state_in = '0;
   logic [LEN_W-1:0] pc_len = '0;
   logic             pt_bit = 1'b0;
   logic             pt_valid = 1'b0;
   logic             pt_ready;
   logic             ct_bit;
   logic             ct_valid;
   logic             busy;
   logic             done;
   logic [292:0]     state_out;

   int   total = 0;
   int   passed = 0;
   logic exp_q[$];

   acorn_encrypt_process #(.LEN_W(LEN_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .state_in  (state_in),
      .pc_len    (pc_len),
      .pt_bit    (pt_bit),
      .pt_valid  (pt_valid),
      .pt_ready  (pt_ready),
      .ct_bit    (ct_bit),
      .ct_valid  (ct_valid),
      .busy      (busy),
      .done      (done),
      .state_out (state_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [292:0] obs,
                      input logic [292:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   function automatic logic [292:0] rand293();
      logic [292:0] r;
      r = '0;
      for (int i = 0; i < 10; i++)
         r = {r[260:0], 32'($urandom())};
      return r;
   endfunction

   // Golden step, cb fixed to 0 for this stage
   function automatic logic [292:0] mstep(
      input  logic [292:0] s,
      input  logic         m,
      input  logic         ca,
      output logic         ks);
      logic [292:0] t;
      logic         fb;
      logic         mj;
      t = s;
      t[289] ^= t[235] ^ t[230];
      t[230] ^= t[196] ^ t[193];
      t[193] ^= t[160] ^ t[154];
      t[154] ^= t[111] ^ t[107];
      t[107] ^= t[66] ^ t[61];
      t[61]  ^= t[23] ^ t[0];
      mj = (t[235] & t[61]) | (t[235] & t[193])
         | (t[61] & t[193]);
      ks = t[12] ^ t[154] ^ mj
         ^ ((t[230] & t[111]) | (~t[230] & t[66]));
      mj = (t[244] & t[23]) | (t[244] & t[160])
         | (t[23] & t[160]);
      fb = t[0] ^ ~t[107] ^ mj ^ (ca & t[196]) ^ m;
      return {fb, t[292:1]};
   endfunction

   always @(negedge clk) begin
      if (rst && ct_valid) begin
         if (exp_q.size() == 0) begin
            chk("ct_unexpected", ct_valid, 1'b0);
         end else begin
            logic e;
            e = exp_q.pop_front();
            chk("ct_bit", ct_bit, e);
         end
      end
   end

   // Called on a negedge; returns on the negedge after done.
   task automatic run(input logic [292:0] s0,
                      input int           len,
                      input logic [63:0]  pat,
                      input bit           rnd,
                      input bit           poke,
                      output logic [292:0] mid);
      logic [292:0] ms;
      logic         k;
      int           cyc;
      int           cnt;
      int           pc;
      ms = s0;
      cnt = 0;
      state_in = s0;
      pc_len = LEN_W'(len);
      start = 1'b1;
      @(negedge clk);
      cyc = 1;
      start = 1'b0;
      state_in = rand293();
      pc_len = LEN_W'($urandom());
      while (cnt < len && cyc < 4 * len + 100) begin
         chk("pt_ready_msg", pt_ready, 1'b1);
         chk("busy_msg", busy, 1'b1);
         chk("state_msg", state_out, ms);
         pt_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         pt_bit = pat[cnt % 64];
         start = poke && (cnt == len / 2);
         if (pt_valid) begin
            ms = mstep(ms, pt_bit, 1'b1, k);
            exp_q.push_back(pt_bit ^ k);
            cnt++;
         end
         @(negedge clk);
         cyc++;
      end
      pt_valid = 1'b0;
      start = 1'b0;
      chk("msg_accepts", cnt, len);
      mid = state_out;
      chk("state_pad_entry", state_out, ms);
      chk("pt_ready_pad", pt_ready, 1'b0);
      for (int i = 0; i < 256; i++)
         ms = mstep(ms, i == 0, i < 128, k);
      pc = 0;
      while (done !== 1'b1 && pc < 400) begin
         start = poke && (pc == 50);
         @(negedge clk);
         cyc++;
         pc++;
      end
      start = 1'b0;
      chk("done_seen", done, 1'b1);
      if (!rnd) chk("done_latency", cyc, len + 257);
      chk("final_state", state_out, ms);
      chk("busy_done", busy, 1'b0);
      @(negedge clk);
      chk("done_pulse", done, 1'b0);
      chk("state_hold", state_out, ms);
      chk("sb_empty", exp_q.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [292:0] mid;
      logic [292:0] s3;
      logic [292:0] s5;
      logic [63:0]  pat;
      int           seen;

      @(negedge clk);
      chk("rst_pt_ready", pt_ready, 1'b0);
      chk("rst_ct_valid", ct_valid, 1'b0);
      chk("rst_ct_bit", ct_bit, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_state", state_out, '0);
      rst = 1'b1;
      @(negedge clk);

      // single bit into zero state: ct=1, state stays 0
      run('0, 1, '1, 1'b0, 1'b0, mid);
      chk("t1_state_after_step", mid, '0);

      // empty message goes straight to padding
      run('0, 0, '0, 1'b0, 1'b0, mid);

      s3 = rand293();
      pat = {32'($urandom()), 32'($urandom())};
      run(s3, 64, pat, 1'b0, 1'b0, mid);
      run(s3, 64, pat, 1'b1, 1'b0, mid);

      // abort in the middle of padding
      s5 = rand293();
      state_in = s5;
      pc_len = '0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (100) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("abort_pt_ready", pt_ready, 1'b0);
      chk("abort_ct_valid", ct_valid, 1'b0);
      chk("abort_ct_bit", ct_bit, 1'b0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_done", done, 1'b0);
      chk("abort_state", state_out, '0);
      @(negedge clk);
      rst = 1'b1;
      seen = 0;
      repeat (300) begin
         @(negedge clk);
         if (done === 1'b1) seen++;
      end
      chk("no_done_after_abort", seen, 0);
      run(s5, 0, '0, 1'b0, 1'b0, mid);

      // stray start pulses in MSG and PAD
      run(s3, 64, pat, 1'b0, 1'b1, mid);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
